// File: rtl/trap_pkg.sv
// Shared types for the trapezoid feeder.
// Vertex word layout and feeder FSM states.
package trap_pkg;

  localparam int WORDS_PER_TRAP = 4;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
  } vertex_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GUARD,
    WAIT
  } feeder_state_e;

endpackage

// File: rtl/trap_word_fifo.sv
// Synchronous vertex-word FIFO with registered read data.
// rd_data holds the popped word for one cycle and is zero otherwise.
module trap_word_fifo
  import trap_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  vertex_t     wr_data,
  input  logic        pop,
  output vertex_t     rd_data,
  output logic [AW:0] count
);

  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  vertex_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic push_ok;
  logic pop_ok;

  assign push_ok = push && (count != FULL);
  assign pop_ok  = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      rd_data <= pop_ok ? mem[rd_ptr] : '0;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/trapezoid_feeder.sv
// Trapezoid renderer vertex feeder: buffers host words and
// issues 4-word bursts on nt/xi/yi when the renderer is idle.
module trapezoid_feeder
  import trap_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  output logic             in_ready,
  input  logic             busy,
  input  logic             po,
  output logic             nt,
  output logic [7:0]       xi,
  output logic [7:0]       yi,
  output logic [CW-1:0]    fifo_count,
  output logic [CNT_W-1:0] trap_sent,
  output logic [CNT_W-1:0] pix_count,
  output logic             idle
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] TRAP_WORDS = CW'(WORDS_PER_TRAP);

  feeder_state_e state;
  logic [1:0] k;
  logic push;
  logic pop;
  logic start;
  vertex_t rd_word;

  assign in_ready = !reset && (fifo_count != FULL);
  assign push = in_valid && in_ready;
  assign start = (state == IDLE) && !busy
              && (fifo_count >= TRAP_WORDS);
  assign pop = start || ((state == SEND) && (k != 2'd3));

  trap_word_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .wr_data(vertex_t'(in_data)),
    .pop    (pop),
    .rd_data(rd_word),
    .count  (fifo_count)
  );

  // FIFO read register is zero outside SEND, so it drives xi/yi directly
  assign xi = rd_word.x;
  assign yi = rd_word.y;

  assign idle = (fifo_count == '0) && (state == IDLE) && !busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      nt        <= 1'b0;
      trap_sent <= '0;
      pix_count <= '0;
    end else begin
      nt <= start;
      pix_count <= pix_count + CNT_W'(po);
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= SEND;
            k     <= '0;
          end
        end
        SEND: begin
          if (k == 2'd3) begin
            state     <= GUARD;
            trap_sent <= trap_sent + 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        GUARD: state <= WAIT;
        WAIT: begin
          if (!busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trapezoid_feeder.sv
// Scoreboard bench for trapezoid_feeder: accepted words are queued,
// a negedge monitor checks each burst against the queue.
module tb_trapezoid_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        busy;
  logic        busy_stim;
  logic        busy_rend;
  logic        po;
  logic        nt;
  logic [7:0]  xi;
  logic [7:0]  yi;
  logic [4:0]  fifo_count;
  logic [31:0] trap_sent;
  logic [31:0] pix_count;
  logic        idle;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  bit  in_burst = 0;
  int  idx = 0;
  int  hold = 0;
  int  cyc = 0;
  int  fall_cyc = 0;
  bit  fall_valid = 0;
  bit  rend_en = 0;
  bit  pix_en = 0;
  int  exp_pix = 0;

  assign busy = busy_stim | busy_rend;

  always #5 clk = ~clk;

  trapezoid_feeder #(
    .DEPTH(16),
    .CNT_W(32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .busy      (busy),
    .po        (po),
    .nt        (nt),
    .xi        (xi),
    .yi        (yi),
    .fifo_count(fifo_count),
    .trap_sent (trap_sent),
    .pix_count (pix_count),
    .idle      (idle)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Monitor, renderer busy model and po generator
  always @(negedge clk) begin
    logic [15:0] w;
    cyc++;
    if (reset) begin
      in_burst = 0;
      idx = 0;
      hold = 0;
      busy_rend = 0;
      po = 0;
      exp_pix = 0;
      fall_valid = 0;
    end else begin
      if (hold > 0) begin
        hold--;
        if (hold == 0) begin
          busy_rend = 0;
          fall_cyc = cyc;
          fall_valid = 1;
        end
      end
      if (!in_burst && nt) begin
        in_burst = 1;
        idx = 0;
        if (fall_valid) begin
          chk("gap_after_busy", 32'(cyc - fall_cyc >= 2), 1);
          fall_valid = 0;
        end
      end
      if (in_burst) begin
        chk("nt_in_burst", 32'(nt), 32'(idx == 0));
        w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
        chk("burst_word", {16'h0, xi, yi}, {16'h0, w});
        if (idx == 3) begin
          in_burst = 0;
          if (rend_en) begin
            busy_rend = 1;
            hold = 50;
          end
        end else begin
          idx++;
        end
      end else begin
        chk("quiet_outputs", {15'h0, nt, xi, yi}, 0);
      end
      po = pix_en && (cyc % 3 != 0);
      if (po) exp_pix++;
    end
  end

  task automatic push_try(input logic [15:0] w, output bit acc);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = w;
    acc = in_ready;
    @(posedge clk);
    if (acc) exp_q.push_back(w);
    #1 in_valid = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] w);
    bit acc = 0;
    int n = 0;
    while (!acc && n < 200) begin
      push_try(w, acc);
      n++;
    end
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_traps(input int n);
    int c = 0;
    while (trap_sent != 32'(n) && c < 600) begin
      @(negedge clk);
      c++;
    end
    chk("trap_sent", trap_sent, 32'(n));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bit acc;
    int n_acc;
    int c;
    logic [15:0] w;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    busy_stim = 1'b0;
    busy_rend = 1'b0;
    po = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_nt", 32'(nt), 0);
    chk("rst_xiyi", {16'h0, xi, yi}, 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_fifo_count", 32'(fifo_count), 0);
    chk("rst_trap_sent", trap_sent, 0);
    chk("rst_pix_count", pix_count, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 1);
    chk("idle_after_rst", 32'(idle), 1);
    pix_en = 1;

    // Single trapezoid
    push_word(16'h1010);
    push_word(16'h3010);
    push_word(16'h0840);
    push_word(16'h3840);
    wait_traps(1);
    chk("single_fifo_empty", 32'(fifo_count), 0);

    // Busy backpressure with renderer model
    rend_en = 1;
    push_word(16'h0102);
    push_word(16'h0304);
    push_word(16'h0506);
    push_word(16'h0708);
    push_word(16'h090A);
    push_word(16'h0B0C);
    push_word(16'h0D0E);
    push_word(16'h0F11);
    wait_traps(3);
    c = 0;
    while (busy_rend && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("busy_release", 32'(busy_rend), 0);
    rend_en = 0;
    repeat (3) @(negedge clk);

    // Partial trapezoid waits for its 4th word
    push_word(16'h2122);
    push_word(16'h2324);
    push_word(16'h2526);
    repeat (20) @(negedge clk);
    chk("partial_count", 32'(fifo_count), 3);
    chk("partial_no_send", trap_sent, 3);
    push_word(16'h2728);
    wait_traps(4);
    chk("partial_drained", 32'(fifo_count), 0);

    // Full FIFO with busy held high
    busy_stim = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      w = {8'(i + 1), 8'(8'hF0 - i)};
      push_try(w, acc);
      if (acc) n_acc++;
    end
    @(negedge clk);
    chk("full_accepted", 32'(n_acc), 16);
    chk("full_count", 32'(fifo_count), 16);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_not_idle", 32'(idle), 0);
    busy_stim = 1'b0;
    wait_traps(8);
    chk("full_drained", 32'(fifo_count), 0);
    chk("queue_drained", 32'(exp_q.size()), 0);

    // Pixel count across all bursts so far
    pix_en = 0;
    repeat (3) @(negedge clk);
    chk("pix_count", pix_count, 32'(exp_pix));

    // Reset during the k=2 cycle of a burst
    push_word(16'h4142);
    push_word(16'h4344);
    push_word(16'h4546);
    push_word(16'h4748);
    c = 0;
    while (!nt && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("mid_burst_start", 32'(nt), 1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_nt", 32'(nt), 0);
    chk("mid_rst_xiyi", {16'h0, xi, yi}, 0);
    chk("mid_rst_count", 32'(fifo_count), 0);
    chk("mid_rst_trap_sent", trap_sent, 0);
    chk("mid_rst_pix", pix_count, 0);
    @(negedge clk);
    reset = 1'b0;
    push_word(16'h5152);
    push_word(16'h5354);
    push_word(16'h5556);
    push_word(16'h5758);
    wait_traps(1);
    chk("post_rst_drained", 32'(fifo_count), 0);
    chk("post_rst_queue", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
